// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage and by the decoder.
//
// Contents:
//   fetch_state_t  - fetch FSM encoding (FETCH_HI=0, FETCH_LO=1, HOLD=2)
//   TWO_BYTE_BIT   - opcode bit that marks a two-byte instruction
//   INST_LEN_1/2   - encoded instruction lengths
//   is_two_byte()  - length rule shared with the decoder's zero_arg logic
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_HI = 2'd0,
      FETCH_LO = 2'd1,
      HOLD     = 2'd2
   } fetch_state_t;

   localparam int TWO_BYTE_BIT = 7;

   localparam logic [1:0] INST_LEN_1 = 2'd1;
   localparam logic [1:0] INST_LEN_2 = 2'd2;

   // An opcode with the top bit set carries one operand byte.
   function automatic logic is_two_byte(input logic [7:0] opcode);
      return opcode[TWO_BYTE_BIT];
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding the decoder.
//
// Reads bytes over a req/ack memory port, assembles 1- or 2-byte
// instructions (opcode in [15:8]) and offers them with a valid/ready
// handshake. A one-byte prefetch buffer lets back-to-back one-byte
// instructions issue every cycle. Execute can redirect the fetch PC at
// any time; redirect beats everything except reset.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_req/mem_addr          byte read request and address
//   mem_ack/mem_rdata         read completion and data (same-cycle ack ok)
//   inst_valid/inst_ready     instruction handshake to decode/execute
//   inst, inst_pc, inst_len   instruction word, opcode address, length
//   inst_next_pc              inst_pc + inst_len (call return address)
//   redirect/redirect_pc      flow change from execute
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [15:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [1:0]        inst_len,
   output logic [ADDR_W-1:0] inst_next_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_t      state;
   logic [ADDR_W-1:0] fpc;
   logic [7:0]        pf_byte;
   logic              pf_valid;
   logic [15:0]       inst_r;
   logic [ADDR_W-1:0] inst_pc_r;
   logic [1:0]        inst_len_r;
   logic [ADDR_W-1:0] inst_next_pc_r;

   logic              take_op;
   logic [7:0]        op_byte;
   logic [ADDR_W-1:0] op_pc;
   logic [ADDR_W-1:0] op_next;

   // Outputs are forced to zero while reset is held so that a reset in the
   // middle of a memory transaction drops mem_req in the same cycle.
   assign mem_req      = !rst && ((state != HOLD) || !pf_valid);
   assign mem_addr     = rst ? '0 : fpc;
   assign inst_valid   = !rst && (state == HOLD);
   assign inst         = rst ? '0 : inst_r;
   assign inst_pc      = rst ? '0 : inst_pc_r;
   assign inst_len     = rst ? '0 : inst_len_r;
   assign inst_next_pc = rst ? '0 : inst_next_pc_r;

   // Decide whether a new opcode is captured this cycle and where it comes
   // from: the memory port (FETCH_HI, or HOLD on accept with a same-cycle
   // ack) or the prefetch buffer (HOLD on accept with a buffered byte). A
   // buffered byte was read from fpc-1, so that is its address.
   always_comb begin
      take_op = 1'b0;
      op_byte = mem_rdata;
      op_pc   = fpc;
      case (state)
         FETCH_HI: take_op = mem_ack;
         HOLD: begin
            if (inst_ready) begin
               if (pf_valid) begin
                  take_op = 1'b1;
                  op_byte = pf_byte;
                  op_pc   = fpc - PC_ONE;
               end else begin
                  take_op = mem_ack;
               end
            end
         end
         default: take_op = 1'b0;
      endcase
      op_next = op_pc + PC_ONE;
   end

   // Fetch FSM and datapath registers. Reset wins, then redirect (which
   // discards any byte acked in the same cycle), then normal sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= FETCH_HI;
         fpc            <= RESET_PC;
         pf_byte        <= 8'h00;
         pf_valid       <= 1'b0;
         inst_r         <= 16'h0000;
         inst_pc_r      <= '0;
         inst_len_r     <= 2'b00;
         inst_next_pc_r <= '0;
      end else if (redirect) begin
         state    <= FETCH_HI;
         fpc      <= redirect_pc;
         pf_valid <= 1'b0;
      end else if (take_op) begin
         inst_r    <= {op_byte, 8'h00};
         inst_pc_r <= op_pc;
         fpc       <= op_next;
         pf_valid  <= 1'b0;
         if (is_two_byte(op_byte)) begin
            state <= FETCH_LO;
         end else begin
            inst_len_r     <= INST_LEN_1;
            inst_next_pc_r <= op_next;
            state          <= HOLD;
         end
      end else begin
         case (state)
            FETCH_LO: begin
               if (mem_ack) begin
                  inst_r[7:0]    <= mem_rdata;
                  fpc            <= fpc + PC_ONE;
                  inst_len_r     <= INST_LEN_2;
                  inst_next_pc_r <= fpc + PC_ONE;
                  state          <= HOLD;
               end
            end
            HOLD: begin
               // Accepted with nothing buffered and no ack: keep the
               // outstanding request alive by moving to FETCH_HI at the
               // same address.
               if (inst_ready) begin
                  state <= FETCH_HI;
               end else if (!pf_valid && mem_ack) begin
                  pf_byte  <= mem_rdata;
                  pf_valid <= 1'b1;
                  fpc      <= fpc + PC_ONE;
               end
            end
            FETCH_HI: state <= FETCH_HI;
            default:  state <= FETCH_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a byte memory model whose ack
// latency is programmable (0 = same-cycle ack).
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic [1:0]  inst_len;
   logic [15:0] inst_next_pc;
   logic        redirect;
   logic [15:0] redirect_pc;

   int tests_run;
   int tests_failed;

   logic [7:0] mem [0:65535];
   int ack_delay;
   int wait_cnt;
   int ack_count;

   inst_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_len     (inst_len),
      .inst_next_pc (inst_next_pc),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: acks once a request has been pending ack_delay cycles.
   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata = mem_ack ? mem[mem_addr] : 8'h00;

   // Wait counter restarts on any completed, dropped or redirected request.
   always @(posedge clk) begin
      if (!mem_req || mem_ack || rst || redirect) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if (mem_ack) ack_count <= ack_count + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests_run++;
      if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b, expected 0", mem_req); end
      tests_run++;
      if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_inst_valid: got %b, expected 0", inst_valid); end
      tests_run++;
      if ({inst, inst_pc, inst_len, inst_next_pc} !== 50'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got inst=%h pc=%h len=%0d next=%h, expected all 0", inst, inst_pc, inst_len, inst_next_pc);
      end
   endtask

   // Zero-wait memory: 0x00 at 0, 0x01 at 1, then a stream of 1-byte ops.
   task automatic test_back_to_back();
      logic [15:0] exp_inst [0:3];
      exp_inst[0] = 16'h0000; exp_inst[1] = 16'h0100;
      exp_inst[2] = 16'h0200; exp_inst[3] = 16'h7F00;
      mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h7F;
      ack_delay  = 0;
      inst_ready = 1'b1;
      rst = 1'b0;
      #1;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         tests_failed++;
         $display("[TB] FAIL first_req: got req=%b addr=%h, expected req=1 addr=0000", mem_req, mem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++;
         if (inst_valid !== 1'b1 || inst !== exp_inst[i] || inst_pc !== 16'(i) ||
             inst_len !== 2'd1 || inst_next_pc !== 16'(i + 1)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_%0d: got v=%b inst=%h pc=%h len=%0d next=%h, expected v=1 inst=%h pc=%h len=1 next=%h",
                     i, inst_valid, inst, inst_pc, inst_len, inst_next_pc, exp_inst[i], 16'(i), 16'(i + 1));
         end
      end
   endtask

   // Two-byte instruction at 0x0010 via redirect, 2-cycle ack latency.
   task automatic test_delayed_two_byte();
      int  cycles;
      logic addr_ok;
      mem[16'h0010] = 8'h85; mem[16'h0011] = 8'h3C;
      inst_ready  = 1'b0;
      ack_delay   = 2;
      redirect    = 1'b1;
      redirect_pc = 16'h0010;
      step();
      redirect = 1'b0;
      cycles   = 0;
      addr_ok  = 1'b1;
      while (inst_valid !== 1'b1 && cycles < 20) begin
         if (cycles < 3 && mem_addr !== 16'h0010) addr_ok = 1'b0;
         if (cycles >= 3 && cycles < 6 && mem_addr !== 16'h0011) addr_ok = 1'b0;
         if (mem_req !== 1'b1) addr_ok = 1'b0;
         step();
         cycles++;
      end
      tests_run++;
      if (addr_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL delayed_addr_stable: got unstable address/request, expected stable"); end
      tests_run++;
      if (cycles != 6) begin tests_failed++; $display("[TB] FAIL delayed_latency: got %0d cycles, expected 6", cycles); end
      tests_run++;
      if (inst !== 16'h853C || inst_pc !== 16'h0010 || inst_len !== 2'd2 || inst_next_pc !== 16'h0012) begin
         tests_failed++;
         $display("[TB] FAIL delayed_result: got inst=%h pc=%h len=%0d next=%h, expected 853C 0010 2 0012", inst, inst_pc, inst_len, inst_next_pc);
      end
   endtask

   // Stall in HOLD for 5 cycles: one prefetch, outputs frozen, then the
   // buffered byte issues on accept without a memory access.
   task automatic test_hold_stall();
      int  acks_before;
      logic stable;
      mem[16'h0012] = 8'h01;
      acks_before = ack_count;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (inst_valid !== 1'b1 || inst !== 16'h853C || inst_pc !== 16'h0010 ||
             inst_len !== 2'd2 || inst_next_pc !== 16'h0012) stable = 1'b0;
         step();
      end
      tests_run++;
      if (stable !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_stable: got changing outputs, expected constant"); end
      tests_run++;
      if (ack_count - acks_before != 1) begin tests_failed++; $display("[TB] FAIL hold_prefetch_count: got %0d, expected 1", ack_count - acks_before); end
      tests_run++;
      if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_pf_full: got mem_req=%b, expected 0", mem_req); end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 16'h0100 || inst_pc !== 16'h0012 || inst_len !== 2'd1 || inst_next_pc !== 16'h0013) begin
         tests_failed++;
         $display("[TB] FAIL pf_issue: got v=%b inst=%h pc=%h len=%0d next=%h, expected 1 0100 0012 1 0013", inst_valid, inst, inst_pc, inst_len, inst_next_pc);
      end
   endtask

   // Redirect in the same cycle as the operand ack in FETCH_LO.
   task automatic test_redirect_fetch_lo();
      mem[16'h0020] = 8'h90; mem[16'h0021] = 8'hAB; mem[16'h0200] = 8'h42;
      ack_delay   = 0;
      redirect    = 1'b1;
      redirect_pc = 16'h0020;
      step();
      redirect = 1'b0;
      step();
      redirect    = 1'b1;
      redirect_pc = 16'h0200;
      #1;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0021 || mem_ack !== 1'b1 || inst_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL redir_setup: got req=%b addr=%h ack=%b v=%b, expected 1 0021 1 0", mem_req, mem_addr, mem_ack, inst_valid);
      end
      step();
      redirect = 1'b0;
      tests_run++;
      if (inst_valid !== 1'b0 || mem_addr !== 16'h0200) begin
         tests_failed++;
         $display("[TB] FAIL redir_addr: got v=%b addr=%h, expected v=0 addr=0200", inst_valid, mem_addr);
      end
      step();
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 16'h4200 || inst_pc !== 16'h0200) begin
         tests_failed++;
         $display("[TB] FAIL redir_issue: got v=%b inst=%h pc=%h, expected 1 4200 0200", inst_valid, inst, inst_pc);
      end
   endtask

   // Two-byte instruction straddling the top of the address space.
   task automatic test_wrap();
      mem[16'hFFFF] = 8'hC0; mem[16'h0000] = 8'h05; mem[16'h0001] = 8'h01;
      ack_delay   = 0;
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      step();
      redirect = 1'b0;
      step();
      step();
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 16'hC005 || inst_pc !== 16'hFFFF || inst_len !== 2'd2 || inst_next_pc !== 16'h0001) begin
         tests_failed++;
         $display("[TB] FAIL wrap: got v=%b inst=%h pc=%h len=%0d next=%h, expected 1 C005 FFFF 2 0001", inst_valid, inst, inst_pc, inst_len, inst_next_pc);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 16'h0100 || inst_pc !== 16'h0001) begin
         tests_failed++;
         $display("[TB] FAIL wrap_next: got v=%b inst=%h pc=%h, expected 1 0100 0001", inst_valid, inst, inst_pc);
      end
   endtask

   // Reset while the operand request is outstanding in FETCH_LO.
   task automatic test_reset_mid();
      mem[16'h0030] = 8'h88;
      ack_delay   = 0;
      redirect    = 1'b1;
      redirect_pc = 16'h0030;
      step();
      redirect = 1'b0;
      step();
      ack_delay = 3;
      #1;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0031 || mem_ack !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_setup: got req=%b addr=%h ack=%b, expected 1 0031 0", mem_req, mem_addr, mem_ack);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_drop: got mem_req=%b, expected 0", mem_req); end
      step();
      tests_run++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_next: got req=%b v=%b, expected 0 0", mem_req, inst_valid);
      end
      rst       = 1'b0;
      ack_delay = 0;
      #1;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         tests_failed++;
         $display("[TB] FAIL rst_restart: got req=%b addr=%h, expected 1 0000", mem_req, mem_addr);
      end
      step();
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 16'h0500 || inst_pc !== 16'h0000 || inst_next_pc !== 16'h0001) begin
         tests_failed++;
         $display("[TB] FAIL rst_restart_inst: got v=%b inst=%h pc=%h next=%h, expected 1 0500 0000 0001", inst_valid, inst, inst_pc, inst_next_pc);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      ack_delay    = 0;
      ack_count    = 0;
      wait_cnt     = 0;
      rst          = 1'b1;
      inst_ready   = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = 16'h0000;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

      test_reset();
      test_back_to_back();
      test_delayed_two_byte();
      test_hold_stall();
      test_redirect_fetch_lo();
      test_wrap();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Reads instruction bytes over a byte-wide req/ack memory port and assembles 1- or 2-byte instructions into a 16-bit word (first byte in [15:8]).
- Presents each instruction with its PC and length to execute/decode through a valid/ready handshake.
- Holds a one-byte prefetch buffer so back-to-back one-byte instructions can issue every cycle, and accepts branch/call/return redirects from execute.

Parameters:
- ADDR_W, 16, width of PC and memory address; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address; stable while mem_req=1 and no ack
- mem_ack  in  1  read complete this cycle; may be high in the same cycle as mem_req
- mem_rdata  in  8  read byte, valid when mem_ack=1
- inst_valid  out  1  inst/inst_pc/inst_len/inst_next_pc are valid
- inst_ready  in  1  consumer accepts the instruction this cycle
- inst  out  16  [15:8]=opcode byte, [7:0]=operand byte or 0x00
- inst_pc  out  ADDR_W  address of the opcode byte
- inst_len  out  2  1 or 2
- inst_next_pc  out  ADDR_W  inst_pc+inst_len, used as the call return address
- redirect  in  1  execute changes flow
- redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Instruction length: opcode bit7=0 gives 1 byte; bit7=1 gives 2 bytes. This matches the decoder's zero_arg rule.
- States: FETCH_HI, FETCH_LO, HOLD.
- Registers: fpc (next fetch address), pf_byte, pf_valid.
- Reset: state=FETCH_HI, fpc=RESET_PC, pf_valid=0.
  - All outputs read 0 during the reset cycle (mem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_len=0, inst_next_pc=0).
  - mem_req rises on the first cycle after rst deasserts.
- FETCH_HI: mem_req=1, mem_addr=fpc. On ack, the opcode byte is captured into inst[15:8] and inst_pc=fpc, then fpc+1.
  - bit7=0: inst[7:0]=0x00, inst_len=1, go to HOLD.
  - bit7=1: go to FETCH_LO.
- FETCH_LO: mem_req=1, mem_addr=fpc. On ack, inst[7:0]=rdata, fpc+1, inst_len=2, go to HOLD.
- HOLD: inst_valid=1; outputs held constant until accepted.
  - If pf_valid=0, the block prefetches: mem_req=1, mem_addr=fpc. On ack, pf_byte=rdata, pf_valid=1, fpc+1.
  - If pf_valid=1, mem_req=0.
- Accept in HOLD (inst_ready=1, redirect=0):
  - pf_valid=1: pf_byte becomes the new opcode with inst_pc=fpc-1, and pf_valid clears. A 1-byte opcode goes to HOLD with inst_valid held high, so there is no bubble. A 2-byte opcode goes to FETCH_LO.
  - pf_valid=0, ack this cycle: the rdata is treated as an opcode capture exactly as in FETCH_HI.
  - pf_valid=0, no ack: go to FETCH_HI. mem_req stays high and mem_addr is unchanged, so the handshake is never broken.
- Redirect priority: redirect overrides everything in any state, including a simultaneous ack, and the acked byte is discarded.
  - Next cycle: state=FETCH_HI, fpc=redirect_pc, pf_valid=0, inst_valid=0.
  - mem_req may drop or change address on redirect. Memory must tolerate an abandoned request.
  - In HOLD, redirect also counts as consuming the current instruction, whether or not inst_ready is high.
- inst_ready while inst_valid=0 is ignored.
- Wrap-around: fpc 0xFFFF+1 = 0x0000. A 2-byte instruction at 0xFFFF reads its operand from 0x0000 and reports inst_pc=0xFFFF, inst_next_pc=0x0001.
- Reset mid-transaction wins over everything: mem_req drops the same cycle, and the state and all buffers are cleared.
- Latency with zero-wait memory (ack in the same cycle as req):
  - 1-byte instruction: valid 1 cycle after its opcode fetch.
  - 2-byte instruction: valid 2 cycles after its opcode fetch starts.
  - Steady stream of 1-byte instructions: 1 instruction per cycle.

Decomposition:
- Shared cpu package: state encodings (FETCH_HI=0, FETCH_LO=1, HOLD=2), TWO_BYTE_BIT=7, INST_LEN_1/INST_LEN_2 constants. The decoder uses the same length rule.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Zero-wait memory holding 0x00,0x01 at 0x0000: reset, release. Inst 0x0000 issues (pc 0, len 1), then 0x0100 (pc 1) on the next cycle with inst_ready=1, with no bubble between them.
- Memory 0x85,0x3C at 0x0010 with fetch started via redirect_pc=0x0010, ack delayed 2 cycles per byte: mem_addr stays stable while waiting. Response is inst=0x853C, inst_pc=0x0010, inst_len=2, inst_next_pc=0x0012.
- inst_ready held low for 5 cycles in HOLD: outputs stay constant, exactly one prefetch request occurs, and pf_valid=1.
- redirect=1, redirect_pc=0x0200 asserted in the same cycle as an ack in FETCH_LO: the byte is dropped, the next mem_addr=0x0200, and no instruction issues from the old stream.
- 2-byte opcode 0xC0 at 0xFFFF, 0x05 at 0x0000: response is inst=0xC005, inst_pc=0xFFFF, inst_next_pc=0x0001.
- rst asserted while mem_req=1 in FETCH_LO: mem_req=0 and inst_valid=0 the next cycle; after release, fetch restarts at RESET_PC.
